uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate in bit/s.
REQ-003 Parameter DATA_WIDTH, default 8: data bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 4: transmit buffer entries, a power of two, at least 2.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_data  input  DATA_WIDTH  upstream word to transmit.
REQ-009 s_ready  output  1  FIFO can accept a word.
REQ-010 tx_o  output  1  serial line, idle high.
REQ-011 busy_o  output  1  a frame is in progress or the FIFO is non-empty.
REQ-012 count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 BAUD_DIV SHALL be the integer quotient CLK_FREQ/BAUD_RATE; every serial bit SHALL last exactly BAUD_DIV clk cycles.
REQ-014 Frame format SHALL be: start bit 0, then DATA_WIDTH data bits LSB first, then one stop bit 1; there is no parity bit.
REQ-015 A push SHALL occur on a clk edge where s_valid=1 and s_ready=1; s_data SHALL be written at the tail of the FIFO.
REQ-016 s_ready SHALL be 1 exactly when count_o<FIFO_DEPTH; s_ready SHALL be registered-state based, with no combinational path from s_valid.
REQ-017 A push while full SHALL be refused: no write and no count change, even if a pop occurs on the same edge.
REQ-018 A push and a pop on the same edge SHALL leave count_o unchanged and SHALL keep FIFO order intact.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count_o SHALL never exceed FIFO_DEPTH and SHALL never go below 0.
REQ-020 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-021 IDLE->START: on an edge where the FSM is in IDLE and count_o>0, the head word SHALL be popped into a shift register, the baud counter cleared, and tx_o driven 0 from that edge.
REQ-022 START->DATA: after BAUD_DIV cycles in START; tx_o SHALL equal data bit 0.
REQ-023 DATA: every BAUD_DIV cycles the shift register SHALL shift right and tx_o SHALL present the next bit.
REQ-024 DATA->STOP: after DATA_WIDTH bit periods, tracked by a bit counter; tx_o SHALL equal 1.
REQ-025 STOP->START: after BAUD_DIV cycles, if count_o>0, the FSM SHALL pop and go directly to START, with no idle gap between frames.
REQ-026 STOP->IDLE: after BAUD_DIV cycles, if count_o=0.
REQ-027 Latency: a push into an empty FIFO while IDLE at edge k SHALL pop at edge k+1, and tx_o SHALL be low from edge k+1.
REQ-028 tx_o SHALL be driven from a register, glitch-free, and SHALL never be X or Z after reset.
REQ-029 busy_o SHALL be 1 when state!=IDLE or count_o>0.
REQ-030 The baud counter SHALL count 0..BAUD_DIV-1 and wrap; it SHALL hold at 0 while IDLE.
REQ-031 A word popped by the FSM SHALL be transmitted to completion; pushes during a frame SHALL not affect the frame in flight.

Reset
REQ-032 Asserting rst_n low SHALL immediately set tx_o=1, s_ready=1, busy_o=0, count_o=0, state=IDLE, and clear the pointers, baud counter, bit counter and shift register.
REQ-033 Reset mid-frame SHALL abort the frame and discard all FIFO contents; the first frame after release SHALL start only after a new push.

Verification (CLK_FREQ=1000, BAUD_RATE=100, so BAUD_DIV=10; FIFO_DEPTH=4)
REQ-034 Push 0xA5 while idle -> tx_o low one cycle after the push, then bits 1,0,1,0,0,1,0,1, then stop bit 1, each bit 10 cycles; frame 100 cycles; busy_o falls after the stop bit.
REQ-035 Push 5 words back-to-back while idle -> first word popped, 4 buffered; s_ready=0 with count_o=4; frames contiguous with no idle cycles; order preserved.
REQ-036 FIFO full and a pop coinciding with s_valid=1 -> push refused, count_o=3 after the edge, and the word is accepted on the following edge.
REQ-037 rst_n low at cycle 45 of a frame -> tx_o=1 asynchronously and count_o=0; after release tx_o stays 1 until a new push.
REQ-038 Push 0x00 then 0xFF -> tx_o low for 90 cycles, high for 10 (stop), low for 10 (start), high for 90 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Frames are 8N1-style: start 0, DATA_WIDTH bits LSB first, one stop 1.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to hold a word
// START | start bit (0) on the line
// DATA  | data bits, LSB first, one per baud period
// STOP  | stop bit (1); pops the next word here if one is waiting
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_valid,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic                          s_ready,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   state_t                state;
   logic [BW-1:0]         baud_cnt;
   logic [NW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [DATA_WIDTH-1:0] head;
   logic                  tx_q;

   logic push;
   logic pop;
   logic baud_wrap;

   // s_ready depends only on registered occupancy, so a push while full is
   // refused even when the FSM pops on the same edge.
   assign s_ready    = (count != DEPTH_C);
   assign push       = s_valid & s_ready;
   assign baud_wrap  = (baud_cnt == BAUD_LAST);
   assign pop        = (count != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_wrap));
   assign head       = mem[rd_ptr];
   assign shreg_next = shreg >> 1;

   assign count_o = count;
   assign tx_o    = tx_q;
   assign busy_o  = (state != IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx_q     <= 1'b1;
               if (pop) begin
                  shreg <= head;
                  tx_q  <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_q     <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     tx_q  <= 1'b1;
                     state <= STOP;
                  end else begin
                     shreg   <= shreg_next;
                     tx_q    <= shreg_next[0];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  // Back-to-back frames: go straight to the next start bit.
                  if (pop) begin
                     shreg <= head;
                     tx_q  <= 1'b0;
                     state <= START;
                  end else begin
                     tx_q  <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx_q     <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-frame-position reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DW       = 8;
   localparam int DEPTH    = 4;
   localparam int BD       = CLK_FREQ / BAUD;
   localparam int FRAME    = (DW + 2) * BD;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          tx_o;
   logic          busy_o;
   logic [2:0]    count_o;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   uart_tx_fifo #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .tx_o(tx_o), .busy_o(busy_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word queue plus the position inside the frame in flight.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] cur;
   bit            active = 1'b0;
   int            pos    = 0;
   bit            m_push;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         active = 1'b0;
         pos    = 0;
      end else begin
         m_push = s_valid && (mq.size() < DEPTH);
         if (!active) begin
            if (mq.size() > 0) begin
               cur    = mq.pop_front();
               active = 1'b1;
               pos    = 0;
            end
         end else if (pos == FRAME - 1) begin
            if (mq.size() > 0) begin
               cur = mq.pop_front();
               pos = 0;
            end else begin
               active = 1'b0;
            end
         end else begin
            pos++;
         end
         if (m_push) mq.push_back(s_data);
      end
   end

   function automatic logic exp_tx();
      if (!active) return 1'b1;
      if (pos < BD) return 1'b0;
      if (pos < (DW + 1) * BD) return cur[(pos - BD) / BD];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_tx",    tx_o,    exp_tx());
         chk("m_count", count_o, mq.size());
         chk("m_ready", s_ready, mq.size() < DEPTH);
         chk("m_busy",  busy_o,  active || (mq.size() > 0));
      end
   end

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy_o !== 1'b0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", busy_o, 1'b0);
   endtask

   initial begin
      int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      int prob[6]   = '{5, 30, 60, 90, 100, 15};
      int n_lo1, n_hi1, n_lo2, n_hi2, n_hi;

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx",    tx_o,    1'b1);
      chk("rst_count", count_o, 3'd0);
      chk("rst_ready", s_ready, 1'b1);
      chk("rst_busy",  busy_o,  1'b0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single 0xA5 frame
      s_valid = 1'b1;
      s_data  = 8'hA5;
      @(negedge clk);
      s_valid = 1'b0;
      chk("a5_before_pop", tx_o, 1'b1);
      for (int i = 1; i <= 101; i++) begin
         @(negedge clk);
         if (i == 1)  chk("a5_start_first", tx_o, 1'b0);
         if (i == 10) chk("a5_start_last",  tx_o, 1'b0);
         if (i >= 11 && i <= 90 && ((i - 11) % 10) == 4)
            chk("a5_bit", tx_o, exp_a5[(i - 11) / 10]);
         if (i == 95)  chk("a5_stop", tx_o, 1'b1);
         if (i == 100) chk("a5_busy_in_stop", busy_o, 1'b1);
         if (i == 101) chk("a5_busy_after", busy_o, 1'b0);
      end
      wait_idle(50);

      // 0x00 then 0xFF: run lengths 90 low, 10 high, 10 low, 90 high
      s_valid = 1'b1;
      s_data  = 8'h00;
      @(negedge clk);
      s_data  = 8'hFF;
      @(negedge clk);
      s_valid = 1'b0;
      n_lo1 = 0; n_hi1 = 0; n_lo2 = 0; n_hi2 = 0;
      for (int i = 1; i <= 200; i++) begin
         if (i > 1) @(negedge clk);
         if (i <= 90 && tx_o === 1'b0) n_lo1++;
         if (i > 90 && i <= 100 && tx_o === 1'b1) n_hi1++;
         if (i > 100 && i <= 110 && tx_o === 1'b0) n_lo2++;
         if (i > 110 && tx_o === 1'b1) n_hi2++;
      end
      chk("ff_lo1", n_lo1, 90);
      chk("ff_hi1", n_hi1, 10);
      chk("ff_lo2", n_lo2, 10);
      chk("ff_hi2", n_hi2, 90);
      wait_idle(50);

      // Five back-to-back pushes, then a push held against a full FIFO
      s_valid = 1'b1;
      s_data  = 8'h11;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         s_data = 8'h11 * (j + 1);
      end
      @(negedge clk);
      chk("full_count", count_o, 3'd4);
      chk("full_ready", s_ready, 1'b0);
      s_data = 8'h3C;
      for (int j = 0; j < 300; j++) begin
         @(negedge clk);
         if (count_o != 3'd4) break;
      end
      chk("full_pop_refused", count_o, 3'd3);
      @(negedge clk);
      chk("accept_after_pop", count_o, 3'd4);
      s_valid = 1'b0;
      wait_idle(800);

      // Reset 45 cycles into a frame with another word buffered
      s_valid = 1'b1;
      s_data  = 8'h5A;
      @(negedge clk);
      s_data  = 8'hC3;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (44) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx",    tx_o,    1'b1);
      chk("midrst_count", count_o, 3'd0);
      chk("midrst_ready", s_ready, 1'b1);
      chk("midrst_busy",  busy_o,  1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_o === 1'b1) n_hi++;
      end
      chk("post_rst_idle_high", n_hi, 20);
      chk("post_rst_busy", busy_o, 1'b0);

      // Randomized traffic with varying offered load and one async reset
      for (int seg = 0; seg < 6; seg++) begin
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 99) < prob[seg]);
            s_data  = DW'($urandom);
            if (seg == 2 && c == 200) begin
               #2 rst_n = 1'b0;
               #3 rst_n = 1'b1;
            end
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      wait_idle(1000);
      chk("final_tx", tx_o, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
